// File: rtl/dcache_ctrl.sv
// Blocking write-back data-cache controller: looks up external line storage and runs
// write-back/refill bursts on the memory port. Define CACHE_PERF_CNT_EN for hit/miss counters.
module dcache_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned LINE_WIDTH  = 6,
  parameter int unsigned CACHE_WIDTH = 6,
  localparam int unsigned TAG_WIDTH  = ADDR_WIDTH - LINE_WIDTH - CACHE_WIDTH,
  localparam int unsigned WORD_WIDTH = LINE_WIDTH - 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_wr,
  input  logic [ADDR_WIDTH-1:0]  cpu_addr,
  input  logic [31:0]            cpu_wdata,
  output logic                   cpu_ready,
  output logic [31:0]            cpu_rdata,
  output logic [CACHE_WIDTH-1:0] line_sel,
  output logic [WORD_WIDTH-1:0]  line_index,
  output logic                   line_we,
  output logic                   line_valid_in,
  output logic [TAG_WIDTH-1:0]   line_tag_in,
  output logic                   line_dirty_in,
  output logic [31:0]            line_data_in,
  input  logic                   line_valid,
  input  logic [TAG_WIDTH-1:0]   line_tag,
  input  logic                   line_dirty,
  input  logic [31:0]            line_data,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic                   mem_ack,
  input  logic                   mem_rvalid,
  input  logic [31:0]            mem_rdata
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]            hit_cnt,
  output logic [31:0]            miss_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StLookup, StWb, StRefill} state_e;

  localparam logic [WORD_WIDTH-1:0] LastBeat = {WORD_WIDTH{1'b1}};

  state_e                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   wr_q;
  logic [31:0]            wdata_q;
  logic [WORD_WIDTH-1:0]  beat_q;
  logic                   first_q;
  logic                   cpu_ready_q;
  logic [31:0]            cpu_rdata_q;

  logic [TAG_WIDTH-1:0]   req_tag;
  logic [CACHE_WIDTH-1:0] req_index;
  logic [WORD_WIDTH-1:0]  req_word;
  logic                   hit;

  assign req_tag   = addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign req_index = addr_q[LINE_WIDTH +: CACHE_WIDTH];
  assign req_word  = addr_q[2 +: WORD_WIDTH];
  assign hit       = line_valid && (line_tag == req_tag);

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;

  // Storage and memory strobes are decoded from the state so writes land in the hit/beat cycle.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = line_data;
    line_sel      = req_index;
    line_index    = req_word;
    line_we       = 1'b0;
    line_valid_in = 1'b0;
    line_tag_in   = req_tag;
    line_dirty_in = 1'b0;
    line_data_in  = wdata_q;
    case (state_q)
      StLookup: begin
        if (hit && wr_q) begin
          line_we       = 1'b1;
          line_valid_in = 1'b1;
          line_dirty_in = 1'b1;
        end
      end
      StWb: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = {line_tag, req_index, {LINE_WIDTH{1'b0}}};
        line_index = beat_q;
      end
      StRefill: begin
        mem_req       = 1'b1;
        mem_addr      = {req_tag, req_index, {LINE_WIDTH{1'b0}}};
        line_index    = beat_q;
        line_we       = mem_rvalid;
        line_valid_in = (beat_q == LastBeat);
        line_data_in  = mem_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      beat_q      <= '0;
      first_q     <= 1'b0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      cpu_ready_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cpu_req) begin
            addr_q  <= cpu_addr;
            wr_q    <= cpu_wr;
            wdata_q <= cpu_wdata;
            first_q <= 1'b1;
            state_q <= StLookup;
          end
        end
        StLookup: begin
          first_q <= 1'b0;
          if (hit) begin
            cpu_ready_q <= 1'b1;
            cpu_rdata_q <= line_data;
            state_q     <= StIdle;
          end else if (line_valid && line_dirty) begin
            state_q <= StWb;
          end else begin
            state_q <= StRefill;
          end
        end
        StWb: begin
          if (mem_ack) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == LastBeat) state_q <= StRefill;
          end
        end
        StRefill: begin
          if (mem_rvalid) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == LastBeat) state_q <= StLookup;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef CACHE_PERF_CNT_EN
  // Only lookups that start a CPU request count; the post-refill re-lookup does not.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state_q == StLookup && first_q) begin
      if (hit) hit_cnt <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a behavioural line store, a burst memory responder
// and a scoreboard of expected load data.
module tb_dcache_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 6;
  localparam int unsigned CW = 6;
  localparam int unsigned TW = AW - LW - CW;
  localparam int unsigned WN = 1 << (LW - 2);
  localparam int unsigned NL = 1 << CW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req = 1'b0;
  logic          cpu_wr = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic          cpu_ready;
  logic [31:0]   cpu_rdata;
  logic [CW-1:0] line_sel;
  logic [LW-3:0] line_index;
  logic          line_we;
  logic          line_valid_in;
  logic [TW-1:0] line_tag_in;
  logic          line_dirty_in;
  logic [31:0]   line_data_in;
  logic          line_valid;
  logic [TW-1:0] line_tag;
  logic          line_dirty;
  logic [31:0]   line_data;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [31:0]   mem_rdata = '0;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;
`endif

  dcache_ctrl #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CACHE_WIDTH(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req       (cpu_req),
    .cpu_wr        (cpu_wr),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_ready     (cpu_ready),
    .cpu_rdata     (cpu_rdata),
    .line_sel      (line_sel),
    .line_index    (line_index),
    .line_we       (line_we),
    .line_valid_in (line_valid_in),
    .line_tag_in   (line_tag_in),
    .line_dirty_in (line_dirty_in),
    .line_data_in  (line_data_in),
    .line_valid    (line_valid),
    .line_tag      (line_tag),
    .line_dirty    (line_dirty),
    .line_data     (line_data),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Line storage with its own valid reset (cleared at time zero).
  logic          st_valid [NL];
  logic [TW-1:0] st_tag   [NL];
  logic          st_dirty [NL];
  logic [31:0]   st_data  [NL][WN];

  assign line_valid = st_valid[line_sel];
  assign line_tag   = st_tag[line_sel];
  assign line_dirty = st_dirty[line_sel];
  assign line_data  = st_data[line_sel][line_index];

  always_ff @(posedge clk) begin
    if (line_we) begin
      st_valid[line_sel]             <= line_valid_in;
      st_tag[line_sel]               <= line_tag_in;
      st_dirty[line_sel]             <= line_dirty_in;
      st_data[line_sel][line_index]  <= line_data_in;
    end
  end

  // Backing memory: written-back words override a fixed address-derived pattern.
  logic [31:0] backing [int];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (backing.exists(int'(a))) return backing[int'(a)];
    if ((a >> 6) == (32'h100 >> 6)) return 32'hA0 + ((a >> 2) & 32'hF);
    return a ^ 32'h5A5A0000;
  endfunction

  int rbeat = 0;
  bit gap = 1'b0;
  always @(posedge clk) begin
    #1;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    if (!mem_req || mem_we) rbeat = 0;
    if (mem_req && mem_we) begin
      mem_ack = 1'b1;
    end else if (mem_req && !(gap && cyc[0])) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(mem_addr + 32'(4 * rbeat));
      rbeat++;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus activity observed between operations.
  int          rf_beats, wb_beats, we_cycles, req_cycles;
  logic [31:0] rf_addr, wb_addr;
  logic [31:0] wb_data [WN];

  always @(negedge clk) begin
    if (rst) begin
      if (mem_req) req_cycles++;
      if (mem_we) we_cycles++;
      if (mem_req && mem_we && mem_ack) begin
        wb_addr = mem_addr;
        if (wb_beats < int'(WN)) wb_data[wb_beats] = mem_wdata;
        backing[int'(mem_addr + 32'(4 * wb_beats))] = mem_wdata;
        wb_beats++;
      end
      if (mem_req && !mem_we && mem_rvalid) begin
        rf_addr = mem_addr;
        rf_beats++;
      end
    end
  end

  task automatic clear_stats();
    rf_beats = 0; wb_beats = 0; we_cycles = 0; req_cycles = 0;
    rf_addr = '0; wb_addr = '0;
  endtask

  typedef struct packed {logic chk; logic [31:0] data;} exp_t;
  exp_t sb[$];
  int ready_cnt = 0;
  int ready_cyc = 0;
  int req_cyc = 0;

  always @(negedge clk) begin
    if (rst && cpu_ready) begin
      ready_cnt++;
      ready_cyc = cyc;
      if (sb.size() == 0) begin
        check("spurious_ready", {31'd0, cpu_ready}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk) check("cpu_rdata", cpu_rdata, e.data);
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                        input logic chk, input logic [31:0] ex);
    int start;
    exp_t e;
    e.chk = chk;
    e.data = ex;
    clear_stats();
    @(posedge clk); #1;
    sb.push_back(e);
    start = ready_cnt;
    cpu_req = 1'b1; cpu_addr = a; cpu_wr = wr; cpu_wdata = wd;
    req_cyc = cyc;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    for (int i = 0; i < 200 && ready_cnt == start; i++) @(negedge clk);
    check("op_done", {31'd0, ready_cnt != start}, 32'd1);
    if (ready_cnt == start) sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int l = 0; l < int'(NL); l++) begin
      st_valid[l] = 1'b0; st_tag[l] = '0; st_dirty[l] = 1'b0;
      for (int w = 0; w < int'(WN); w++) st_data[l][w] = '0;
    end
    clear_stats();
    repeat (3) @(negedge clk);
    check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_line_we", {31'd0, line_we}, 32'd0);
    rst = 1'b1;

    // Cold load: clean miss, full refill.
    run_op(32'h100, 1'b0, 32'h0, 1'b1, 32'hA0);
    check("cold_rf_beats", rf_beats, 16);
    check("cold_rf_addr", rf_addr, 32'h100);
    check("cold_wb_beats", wb_beats, 0);
    check("cold_mem_we", we_cycles, 0);
    check("cold_valid", {31'd0, st_valid[4]}, 32'd1);
`ifdef CACHE_PERF_CNT_EN
    check("cold_miss_cnt", miss_cnt, 1);
    check("cold_hit_cnt", hit_cnt, 0);
`endif

    // Load hit.
    run_op(32'h104, 1'b0, 32'h0, 1'b1, 32'hA1);
    check("hit_latency", ready_cyc - req_cyc, 2);
    check("hit_no_mem_req", req_cycles, 0);
`ifdef CACHE_PERF_CNT_EN
    check("hit_hit_cnt", hit_cnt, 1);
`endif

    // Store hit marks the line dirty.
    run_op(32'h108, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
    check("st_latency", ready_cyc - req_cyc, 2);
    check("st_word", st_data[4][2], 32'hDEADBEEF);
    check("st_neighbour", st_data[4][1], 32'hA1);
    check("st_dirty", {31'd0, st_dirty[4]}, 32'd1);
    check("st_tag", {12'd0, st_tag[4]}, 32'd0);
    check("st_no_mem_req", req_cycles, 0);

    // Conflict miss on a dirty line: write-back then refill.
    run_op(32'h1108, 1'b0, 32'h0, 1'b1, 32'h5A5A1108);
    check("wb_beats", wb_beats, 16);
    check("wb_addr", wb_addr, 32'h100);
    check("wb_beat0", wb_data[0], 32'hA0);
    check("wb_beat2", wb_data[2], 32'hDEADBEEF);
    check("wb_beat15", wb_data[15], 32'hAF);
    check("wb_rf_beats", rf_beats, 16);
    check("wb_rf_addr", rf_addr, 32'h1100);
    check("wb_rf_word0", st_data[4][0], 32'h5A5A1100);
    check("wb_rf_tag", {12'd0, st_tag[4]}, 32'd1);
    check("wb_rf_dirty", {31'd0, st_dirty[4]}, 32'd0);

    // Clean miss back to the written-back line.
    run_op(32'h108, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF);
    check("clean_wb_beats", wb_beats, 0);
    check("clean_mem_we", we_cycles, 0);
    check("clean_rf_addr", rf_addr, 32'h100);
`ifdef CACHE_PERF_CNT_EN
    check("pre_rst_hit_cnt", hit_cnt, 2);
    check("pre_rst_miss_cnt", miss_cnt, 3);
`endif

    // Reset in the middle of a refill burst.
    clear_stats();
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = 32'h2208; cpu_wr = 1'b0;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    for (int i = 0; i < 100 && rf_beats < 8; i++) @(negedge clk);
    check("mid_rf_reached", rf_beats, 8);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    check("mid_rst_line_we", {31'd0, line_we}, 32'd0);
    rst = 1'b1;
    check("mid_rst_line_invalid", {31'd0, st_valid[8]}, 32'd0);
`ifdef CACHE_PERF_CNT_EN
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
`endif

    // Reload misses and refills fully, with gaps between beats.
    gap = 1'b1;
    run_op(32'h2208, 1'b0, 32'h0, 1'b1, 32'h5A5A2208);
    check("reload_rf_beats", rf_beats, 16);
    check("reload_rf_addr", rf_addr, 32'h2200);
    gap = 1'b0;
    run_op(32'h2200, 1'b0, 32'h0, 1'b1, 32'h5A5A2200);
    check("reload_hit_no_mem", req_cycles, 0);
`ifdef CACHE_PERF_CNT_EN
    check("end_hit_cnt", hit_cnt, 1);
    check("end_miss_cnt", miss_cnt, 1);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
